// File: rtl/cosim_pkg.sv
// Shared FSM encoding and shift-line depth limits for the co-simulation response checker.
// Latency: none; types and constants only.
// Backpressure: none.
package cosim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } cosim_state_e;

    // Legal range of the settle delay (cycles from vec_valid to comparison).
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 8;

endpackage

// File: rtl/cosim_resp_checker_if.sv
// Stimulus and result bundle between a co-simulation harness and the response checker.
// Latency: none; wires only.
// Backpressure: none; the checker accepts one vector per cycle while running.
interface cosim_resp_checker_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic                    start;
    logic                    finish;
    logic                    vec_valid;
    logic signed [WIDTH-1:0] golden;
    logic signed [WIDTH-1:0] netlist;

    logic [CNT_W-1:0]        vec_cnt;
    logic [CNT_W-1:0]        mismatch_cnt;
    logic signed [WIDTH-1:0] first_golden;
    logic signed [WIDTH-1:0] first_netlist;
    logic [CNT_W-1:0]        first_idx;
    logic                    busy;
    logic                    done;
    logic                    pass;

    // Harness side: drives stimulus, observes results.
    modport master (
        output start, finish, vec_valid, golden, netlist,
        input  vec_cnt, mismatch_cnt, first_golden, first_netlist, first_idx,
        input  busy, done, pass
    );

    // Checker side.
    modport slave (
        input  start, finish, vec_valid, golden, netlist,
        output vec_cnt, mismatch_cnt, first_golden, first_netlist, first_idx,
        output busy, done, pass
    );
endinterface

// File: rtl/cosim_settle_pipe.sv
// SETTLE-deep 1-bit tag delay line marking which cycles carry a settled vector to compare.
// Latency: tag_out follows tag_in by exactly SETTLE cycles; clr empties every stage on the next edge.
// Backpressure: none; accepts a tag every cycle.
module cosim_settle_pipe
    import cosim_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic tag_in,
    output logic tag_out,
    output logic in_flight
);

    if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("cosim_settle_pipe: SETTLE out of range");
    end

    logic [SETTLE-1:0] line_q;
    logic [SETTLE-1:0] line_d;
    logic [SETTLE-1:0] shifted;

    if (SETTLE == 1) begin : g_one
        assign shifted = tag_in;
    end else begin : g_many
        assign shifted = {line_q[SETTLE-2:0], tag_in};
    end

    // Advance the line one stage per cycle; clear wins over a new tag.
    always_comb begin
        line_d = shifted;
        if (clr) begin
            line_d = '0;
        end
    end

    // Line register; reset arrives through clr.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    // The exiting stage still counts as in flight: its comparison lands this cycle.
    assign tag_out   = line_q[SETTLE-1];
    assign in_flight = |line_q;

endmodule

// File: rtl/cosim_resp_checker.sv
// Compares reference-model and netlist outputs SETTLE cycles after each vector, counting totals and capturing the first mismatch.
// Latency: counters update SETTLE+1 edges after vec_valid is sampled; done rises once the shift line drains after finish.
// Backpressure: none; one vector per cycle is accepted in RUN, pulses outside RUN are dropped.
module cosim_resp_checker
    import cosim_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cosim_resp_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cosim_state_e            state_q, state_d;
    logic [CNT_W-1:0]        vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]        mismatch_cnt_q, mismatch_cnt_d;
    logic [CNT_W-1:0]        first_idx_q, first_idx_d;
    logic signed [WIDTH-1:0] first_golden_q, first_golden_d;
    logic signed [WIDTH-1:0] first_netlist_q, first_netlist_d;
    logic                    first_seen_q, first_seen_d;

    logic session_clr;
    logic accept;
    logic cmp_vld;
    logic cmp_miss;
    logic in_flight;

    assign accept   = (state_q == ST_RUN) && bus.vec_valid;
    assign cmp_miss = cmp_vld && (bus.golden != bus.netlist);

    cosim_settle_pipe #(
        .SETTLE (SETTLE)
    ) u_settle_pipe (
        .clk       (clk),
        .clr       (rst | session_clr),
        .tag_in    (accept),
        .tag_out   (cmp_vld),
        .in_flight (in_flight)
    );

    // Session FSM; a new session start also flags a clear of counters and captures.
    always_comb begin
        state_d     = state_q;
        session_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_RUN;
                    session_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.finish) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!in_flight) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_d     = ST_RUN;
                    session_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating counters and first-mismatch capture; comparisons happen whenever a tag exits.
    always_comb begin
        vec_cnt_d       = vec_cnt_q;
        mismatch_cnt_d  = mismatch_cnt_q;
        first_idx_d     = first_idx_q;
        first_golden_d  = first_golden_q;
        first_netlist_d = first_netlist_q;
        first_seen_d    = first_seen_q;
        if (session_clr) begin
            vec_cnt_d       = '0;
            mismatch_cnt_d  = '0;
            first_idx_d     = '0;
            first_golden_d  = '0;
            first_netlist_d = '0;
            first_seen_d    = 1'b0;
        end else if (cmp_vld) begin
            if (vec_cnt_q != CNT_MAX) begin
                vec_cnt_d = vec_cnt_q + 1'b1;
            end
            if (cmp_miss) begin
                if (mismatch_cnt_q != CNT_MAX) begin
                    mismatch_cnt_d = mismatch_cnt_q + 1'b1;
                end
                if (!first_seen_q) begin
                    first_seen_d    = 1'b1;
                    first_idx_d     = vec_cnt_q;
                    first_golden_d  = bus.golden;
                    first_netlist_d = bus.netlist;
                end
            end
        end
    end

    // State and result registers; reset beats start, finish and any exiting comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            vec_cnt_q       <= '0;
            mismatch_cnt_q  <= '0;
            first_idx_q     <= '0;
            first_golden_q  <= '0;
            first_netlist_q <= '0;
            first_seen_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            vec_cnt_q       <= vec_cnt_d;
            mismatch_cnt_q  <= mismatch_cnt_d;
            first_idx_q     <= first_idx_d;
            first_golden_q  <= first_golden_d;
            first_netlist_q <= first_netlist_d;
            first_seen_q    <= first_seen_d;
        end
    end

    assign bus.vec_cnt       = vec_cnt_q;
    assign bus.mismatch_cnt  = mismatch_cnt_q;
    assign bus.first_idx     = first_idx_q;
    assign bus.first_golden  = first_golden_q;
    assign bus.first_netlist = first_netlist_q;
    assign bus.busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.pass          = (state_q == ST_DONE) && (mismatch_cnt_q == '0);

endmodule

// File: tb/tb_cosim_resp_checker.sv
// Bench for cosim_resp_checker: two instances (16-bit and 4-bit counters) share one stimulus stream.
// Latency: stimulus golden/netlist values are delayed SETTLE cycles to line up with the comparison.
// Backpressure: none.
module tb_cosim_resp_checker;

    localparam int WIDTH  = 32;
    localparam int SETTLE = 2;
    localparam int CNT_A  = 16;
    localparam int CNT_B  = 4;
    localparam int MAX_A  = 65535;
    localparam int MAX_B  = 15;

    typedef struct packed {
        logic [31:0] g;
        logic [31:0] n;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        finish;
    logic        vec_valid;
    logic [31:0] golden;
    logic [31:0] netlist;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t exp_q[$];
    logic [31:0] dl_g [0:SETTLE];
    logic [31:0] dl_n [0:SETTLE];

    always #5 clk = ~clk;

    cosim_resp_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_A)) bus_a ();
    cosim_resp_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_B)) bus_b ();

    assign bus_a.start     = start;
    assign bus_a.finish    = finish;
    assign bus_a.vec_valid = vec_valid;
    assign bus_a.golden    = golden;
    assign bus_a.netlist   = netlist;
    assign bus_b.start     = start;
    assign bus_b.finish    = finish;
    assign bus_b.vec_valid = vec_valid;
    assign bus_b.golden    = golden;
    assign bus_b.netlist   = netlist;

    cosim_resp_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    cosim_resp_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // One clock period of stimulus; golden/netlist of a vector appear SETTLE cycles after its vec_valid.
    task automatic cycle(input logic r, input logic st, input logic fin, input logic vv,
                         input logic [31:0] g, input logic [31:0] n);
        rst       = r;
        start     = st;
        finish    = fin;
        vec_valid = vv;
        for (int i = SETTLE; i > 0; i--) begin
            dl_g[i] = dl_g[i-1];
            dl_n[i] = dl_n[i-1];
        end
        dl_g[0] = g;
        dl_n[0] = n;
        golden  = dl_g[SETTLE];
        netlist = dl_n[SETTLE];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Accepted vector: driven and recorded in the scoreboard.
    task automatic vec(input logic [31:0] g, input logic [31:0] n);
        vec_t v;
        v.g = g;
        v.n = n;
        exp_q.push_back(v);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, g, n);
    endtask

    // Drains the scoreboard into expected session totals (unsaturated).
    task automatic score(output int cnt, output int mis, output int fidx,
                         output logic [31:0] fg, output logic [31:0] fn);
        vec_t v;
        cnt  = 0;
        mis  = 0;
        fidx = 0;
        fg   = '0;
        fn   = '0;
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            if (v.g !== v.n) begin
                if (mis == 0) begin
                    fidx = cnt;
                    fg   = v.g;
                    fn   = v.n;
                end
                mis++;
            end
            cnt++;
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic wait_done(input string tag);
        int k = 0;
        while (bus_a.done !== 1'b1 && k < 30) begin
            idle();
            k++;
        end
        n_cmp++;
        if (bus_a.done !== 1'b1) begin n_bad++; $display("FAIL %s_done_timeout: done=%b after %0d cycles, want 1", tag, bus_a.done, k); end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0);
        n_cmp++; if (bus_a.vec_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_vec_cnt: got %0d want 0", bus_a.vec_cnt); end
        n_cmp++; if (bus_a.mismatch_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_mismatch_cnt: got %0d want 0", bus_a.mismatch_cnt); end
        n_cmp++; if (bus_a.first_idx !== 16'd0) begin n_bad++; $display("FAIL reset_first_idx: got %0d want 0", bus_a.first_idx); end
        n_cmp++; if (bus_a.first_golden !== 32'd0 || bus_a.first_netlist !== 32'd0) begin n_bad++; $display("FAIL reset_first_capture: got %h/%h want 0/0", bus_a.first_golden, bus_a.first_netlist); end
        n_cmp++; if ({bus_a.busy, bus_a.done, bus_a.pass} !== 3'b000) begin n_bad++; $display("FAIL reset_status: got busy/done/pass=%b want 000", {bus_a.busy, bus_a.done, bus_a.pass}); end
        n_cmp++; if (bus_b.vec_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_vec_cnt_b: got %0d want 0", bus_b.vec_cnt); end
        idle();
    endtask

    // start and finish together in IDLE only start; a later finish with nothing in flight drains in one cycle.
    task automatic test_start_finish_same();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        repeat (3) idle();
        n_cmp++; if ({bus_a.busy, bus_a.done} !== 2'b10) begin n_bad++; $display("FAIL same_cycle_run: got busy/done=%b want 10", {bus_a.busy, bus_a.done}); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        n_cmp++; if ({bus_a.busy, bus_a.done} !== 2'b10) begin n_bad++; $display("FAIL empty_drain_cycle1: got busy/done=%b want 10", {bus_a.busy, bus_a.done}); end
        idle();
        n_cmp++; if ({bus_a.busy, bus_a.done, bus_a.pass} !== 3'b011) begin n_bad++; $display("FAIL empty_drain_done: got busy/done/pass=%b want 011", {bus_a.busy, bus_a.done, bus_a.pass}); end
        n_cmp++; if (bus_a.vec_cnt !== 16'd0) begin n_bad++; $display("FAIL empty_session_vec_cnt: got %0d want 0", bus_a.vec_cnt); end
    endtask

    task automatic test_all_match();
        int cnt, mis, fidx;
        logic [31:0] fg, fn, r;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            vec(r, r);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        wait_done("match");
        score(cnt, mis, fidx, fg, fn);
        n_cmp++; if (bus_a.vec_cnt !== cnt[15:0]) begin n_bad++; $display("FAIL match_vec_cnt: got %0d want %0d", bus_a.vec_cnt, cnt); end
        n_cmp++; if (bus_a.mismatch_cnt !== mis[15:0]) begin n_bad++; $display("FAIL match_mismatch_cnt: got %0d want %0d", bus_a.mismatch_cnt, mis); end
        n_cmp++; if (bus_a.pass !== 1'b1) begin n_bad++; $display("FAIL match_pass: got %b want 1", bus_a.pass); end
    endtask

    task automatic test_mismatch();
        int cnt, mis, fidx;
        logic [31:0] fg, fn;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        n_cmp++; if (bus_a.vec_cnt !== 16'd0) begin n_bad++; $display("FAIL restart_clears_vec_cnt: got %0d want 0", bus_a.vec_cnt); end
        for (int i = 0; i < 10; i++) begin
            vec(32'habcdefab, (i == 3 || i == 7) ? 32'habcdefaa : 32'habcdefab);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        wait_done("mismatch");
        score(cnt, mis, fidx, fg, fn);
        n_cmp++; if (bus_a.vec_cnt !== cnt[15:0]) begin n_bad++; $display("FAIL mm_vec_cnt: got %0d want %0d", bus_a.vec_cnt, cnt); end
        n_cmp++; if (bus_a.mismatch_cnt !== mis[15:0]) begin n_bad++; $display("FAIL mm_mismatch_cnt: got %0d want %0d", bus_a.mismatch_cnt, mis); end
        n_cmp++; if (bus_a.first_idx !== fidx[15:0]) begin n_bad++; $display("FAIL mm_first_idx: got %0d want %0d", bus_a.first_idx, fidx); end
        n_cmp++; if (bus_a.first_golden !== fg) begin n_bad++; $display("FAIL mm_first_golden: got %h want %h", bus_a.first_golden, fg); end
        n_cmp++; if (bus_a.first_netlist !== fn) begin n_bad++; $display("FAIL mm_first_netlist: got %h want %h", bus_a.first_netlist, fn); end
        n_cmp++; if ({bus_a.done, bus_a.pass} !== 2'b10) begin n_bad++; $display("FAIL mm_done_pass: got %b want 10", {bus_a.done, bus_a.pass}); end
    endtask

    // finish one cycle after the last vector: the finish cycle itself carries a comparison, DRAIN lasts SETTLE cycles.
    task automatic test_drain_timing();
        int cnt, mis, fidx, drain_len;
        logic [31:0] fg, fn;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vec(32'h11111111, 32'h11111111);
        vec(32'h22222222, 32'h22222220);
        vec(32'h33333333, 32'h33333330);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        drain_len = 0;
        while (bus_a.busy === 1'b1 && drain_len < 10) begin
            drain_len++;
            idle();
        end
        score(cnt, mis, fidx, fg, fn);
        n_cmp++; if (drain_len !== SETTLE) begin n_bad++; $display("FAIL drain_len: got %0d cycles want %0d", drain_len, SETTLE); end
        n_cmp++; if (bus_a.done !== 1'b1) begin n_bad++; $display("FAIL drain_done: got %b want 1", bus_a.done); end
        n_cmp++; if (bus_a.vec_cnt !== cnt[15:0]) begin n_bad++; $display("FAIL drain_vec_cnt: got %0d want %0d", bus_a.vec_cnt, cnt); end
        n_cmp++; if (bus_a.mismatch_cnt !== mis[15:0]) begin n_bad++; $display("FAIL drain_mismatch_cnt: got %0d want %0d", bus_a.mismatch_cnt, mis); end
        n_cmp++; if (bus_a.first_idx !== fidx[15:0]) begin n_bad++; $display("FAIL drain_first_idx: got %0d want %0d", bus_a.first_idx, fidx); end
    endtask

    task automatic test_saturate();
        int cnt, mis, fidx;
        logic [31:0] fg, fn;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        n_cmp++; if (bus_a.first_golden !== 32'd0) begin n_bad++; $display("FAIL restart_clears_capture: got %h want 0", bus_a.first_golden); end
        for (int i = 0; i < 20; i++) begin
            vec(32'h1000 + i, ~(32'h1000 + i));
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        wait_done("saturate");
        score(cnt, mis, fidx, fg, fn);
        n_cmp++; if (bus_b.vec_cnt !== sat(cnt, MAX_B)) begin n_bad++; $display("FAIL sat_vec_cnt_b: got %0d want %0d", bus_b.vec_cnt, sat(cnt, MAX_B)); end
        n_cmp++; if (bus_b.mismatch_cnt !== sat(mis, MAX_B)) begin n_bad++; $display("FAIL sat_mismatch_cnt_b: got %0d want %0d", bus_b.mismatch_cnt, sat(mis, MAX_B)); end
        n_cmp++; if (bus_a.vec_cnt !== sat(cnt, MAX_A)) begin n_bad++; $display("FAIL sat_vec_cnt_a: got %0d want %0d", bus_a.vec_cnt, sat(cnt, MAX_A)); end
        n_cmp++; if (bus_a.mismatch_cnt !== sat(mis, MAX_A)) begin n_bad++; $display("FAIL sat_mismatch_cnt_a: got %0d want %0d", bus_a.mismatch_cnt, sat(mis, MAX_A)); end
        n_cmp++; if (bus_b.first_golden !== fg) begin n_bad++; $display("FAIL sat_first_golden_b: got %h want %h", bus_b.first_golden, fg); end
    endtask

    task automatic test_rst_midrun();
        int cnt, mis, fidx;
        logic [31:0] fg, fn;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vec(32'h5, 32'h6);
        vec(32'h7, 32'h8);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        exp_q.delete();
        n_cmp++; if (bus_a.vec_cnt !== 16'd0 || bus_a.mismatch_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", bus_a.vec_cnt, bus_a.mismatch_cnt); end
        n_cmp++; if (bus_a.first_golden !== 32'd0) begin n_bad++; $display("FAIL rst_mid_capture: got %h want 0", bus_a.first_golden); end
        n_cmp++; if ({bus_a.busy, bus_a.done, bus_a.pass} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_status: got %b want 000", {bus_a.busy, bus_a.done, bus_a.pass}); end
        repeat (3) idle();
        n_cmp++; if (bus_a.vec_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_mid_pipe_flushed: got %0d want 0", bus_a.vec_cnt); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vec(32'h9, 32'h9);
        vec(32'ha, 32'ha);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        wait_done("rst_restart");
        score(cnt, mis, fidx, fg, fn);
        n_cmp++; if (bus_a.vec_cnt !== cnt[15:0]) begin n_bad++; $display("FAIL rst_restart_vec_cnt: got %0d want %0d", bus_a.vec_cnt, cnt); end
    endtask

    task automatic test_ignored();
        int cnt, mis, fidx;
        logic [31:0] fg, fn;
        logic [15:0] held;
        held = bus_a.vec_cnt;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h2);
        repeat (4) idle();
        n_cmp++; if (bus_a.vec_cnt !== held) begin n_bad++; $display("FAIL ignored_in_done: got %0d want %0d", bus_a.vec_cnt, held); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h2);
        repeat (4) idle();
        n_cmp++; if (bus_a.vec_cnt !== 16'd0) begin n_bad++; $display("FAIL ignored_in_idle: got %0d want 0", bus_a.vec_cnt); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vec(32'hc, 32'hc);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h3, 32'h4);
        wait_done("ignored_drain");
        score(cnt, mis, fidx, fg, fn);
        n_cmp++; if (bus_a.vec_cnt !== cnt[15:0] || bus_a.mismatch_cnt !== mis[15:0]) begin n_bad++; $display("FAIL ignored_in_drain: got %0d/%0d want %0d/%0d", bus_a.vec_cnt, bus_a.mismatch_cnt, cnt, mis); end
    endtask

    initial begin
        for (int i = 0; i <= SETTLE; i++) begin
            dl_g[i] = '0;
            dl_n[i] = '0;
        end
        rst       = 1'b1;
        start     = 1'b0;
        finish    = 1'b0;
        vec_valid = 1'b0;
        golden    = '0;
        netlist   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_start_finish_same();
        test_all_match();
        test_mismatch();
        test_drain_timing();
        test_saturate();
        test_rst_midrun();
        test_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
